// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake; MUL/DIV datapath enabled by ALU_MC_MULDIV_EN
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic             accept, go_busy, busy_last;
    logic [WIDTH:0]   add_s, sub_s;
    logic [WIDTH-1:0] c_x, c_y;
    logic             c_err;

    assign accept = in_valid && in_ready;
    assign add_s  = {1'b0, a} + {1'b0, b};
    assign sub_s  = {1'b0, a} - {1'b0, b};

    always_comb begin
        c_x   = '0;
        c_y   = '0;
        c_err = 1'b0;
        case (opcode)
            4'd0:  begin c_x = add_s[WIDTH-1:0]; c_y = WIDTH'(add_s[WIDTH]); end
            4'd1:  begin c_x = sub_s[WIDTH-1:0]; c_y = WIDTH'(sub_s[WIDTH]); end
            4'd2:  c_x = a & b;
            4'd3:  c_x = a | b;
            4'd4:  c_x = a ^ b;
            4'd5:  c_x = ~a;
            4'd6:  begin c_x = {a[WIDTH-2:0], 1'b0}; c_y = WIDTH'(a[WIDTH-1]); end
            4'd7:  begin c_x = {1'b0, a[WIDTH-1:1]}; c_y = WIDTH'(a[0]); end
            4'd8:  c_x = {a[WIDTH-2:0], a[WIDTH-1]};
            4'd9:  c_x = {a[0], a[WIDTH-1:1]};
            4'd10: begin c_x = a + WIDTH'(1); c_y = WIDTH'(&a); end
            4'd11: begin c_x = a - WIDTH'(1); c_y = WIDTH'(~|a); end
            4'd12: begin c_x = WIDTH'(a < b); c_y = WIDTH'(a == b); end
            4'd13: c_x = a;
            // MUL/DIV: the single-cycle result is the "not built" answer
            default: c_err = 1'b1;
        endcase
    end

`ifdef ALU_MC_MULDIV_EN
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi, lo, opnd, hi_nxt, lo_nxt, rem_sub;
    logic [WIDTH:0]   mul_s, rem_sh;
    logic [CW-1:0]    cnt;
    logic             is_div, div0, ge;

    assign go_busy   = opcode[3:1] == 3'b111;
    assign busy_last = cnt == CW'(WIDTH - 1);

    // hi:lo is product (MUL) or remainder:quotient (DIV); opnd is multiplicand/divisor
    assign mul_s   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign rem_sh  = {hi, lo[WIDTH-1]};
    assign ge      = rem_sh >= {1'b0, opnd};
    assign rem_sub = rem_sh[WIDTH-1:0] - opnd;

    always_comb begin
        if (is_div) begin
            hi_nxt = ge ? rem_sub : rem_sh[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], ge};
        end else begin
            hi_nxt = mul_s[WIDTH:1];
            lo_nxt = {mul_s[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            div0   <= 1'b0;
        end else if (accept && go_busy) begin
            hi     <= '0;
            lo     <= opcode[0] ? a : b;
            opnd   <= opcode[0] ? b : a;
            cnt    <= '0;
            is_div <= opcode[0];
            div0   <= b == '0;
        end else if (state == BUSY) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + CW'(1);
        end
    end
`else
    assign go_busy   = 1'b0;
    assign busy_last = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = go_busy ? BUSY : DONE;
            BUSY:    if (busy_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && rst_n;
        out_valid = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x    <= '0;
            y    <= '0;
            zero <= 1'b0;
            err  <= 1'b0;
        end else if (accept && !go_busy) begin
            x    <= c_x;
            y    <= c_y;
            zero <= c_x == '0;
            err  <= c_err;
        end
`ifdef ALU_MC_MULDIV_EN
        else if (state == BUSY && busy_last) begin
            x    <= lo_nxt;
            y    <= hi_nxt;
            zero <= lo_nxt == '0;
            err  <= is_div && div0;
        end
`endif
    end
endmodule
